freq_status_monitor: RTL and testbench

FREQ_STATUS_MONITOR -- requirements
Module: freq_status_monitor

---
 rtl/freq_status_monitor.sv | 250 +++++++++++++++++++++++++
 tb/tb_freq_status_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_status_monitor.sv
// freq_status_monitor: classifies a once-per-second frequency measurement
// against a nominal value and tolerance, and tracks lock status.
//
// SEC_I starts a C_SAMPLE_DLY-cycle delay. When the delay expires,
// FREQ_HZ_I is captured into FREQ_HZ_O and EVAL_VALID_O pulses.
// The following edge updates the state, the streak counters, the sticky
// alarm and the optional min/max trackers.
//
// Optional feature macro: FREQ_STATUS_MONITOR_MINMAX_EN builds the
// FREQ_MIN_O/FREQ_MAX_O trackers. When the macro is undefined, both
// outputs are tied to 0.
//
// Ports:
//   SYS_CLK_I       clock
//   SYS_RSTN_I      async active-low reset (release synchronised inside)
//   SEC_I           one-cycle one-second pulse
//   FREQ_HZ_I       measured frequency
//   EXPECT_HZ_I     nominal frequency
//   TOL_HZ_I        allowed absolute deviation
//   STICKY_CLR_I    clears the sticky alarm and the min/max trackers
//   EVAL_VALID_O    one-cycle pulse per evaluation
//   STATE_O         0 INIT, 1 LOCKED, 2 UNLOCKED, 3 LOST
//   FREQ_OK_O       state is LOCKED
//   CLK_LOST_O      state is LOST
//   ALARM_STICKY_O  latched fault flag
//   FREQ_HZ_O       last sampled frequency
//   FREQ_MIN_O      smallest non-zero sample since the last clear
//   FREQ_MAX_O      largest non-zero sample since the last clear
module freq_status_monitor #(
  parameter int unsigned C_CNT_BW     = 32,
  parameter int unsigned C_SAMPLE_DLY = 8,
  parameter int unsigned C_GOOD_CNT   = 3,
  parameter int unsigned C_BAD_CNT    = 2
) (
  input  logic                SYS_CLK_I,
  input  logic                SYS_RSTN_I,
  input  logic                SEC_I,
  input  logic [C_CNT_BW-1:0] FREQ_HZ_I,
  input  logic [C_CNT_BW-1:0] EXPECT_HZ_I,
  input  logic [C_CNT_BW-1:0] TOL_HZ_I,
  input  logic                STICKY_CLR_I,
  output logic                EVAL_VALID_O,
  output logic [1:0]          STATE_O,
  output logic                FREQ_OK_O,
  output logic                CLK_LOST_O,
  output logic                ALARM_STICKY_O,
  output logic [C_CNT_BW-1:0] FREQ_HZ_O,
  output logic [C_CNT_BW-1:0] FREQ_MIN_O,
  output logic [C_CNT_BW-1:0] FREQ_MAX_O
);

  localparam int unsigned EXT_W  = C_CNT_BW + 1;
  localparam int unsigned DLY_W  = 8;
  localparam int unsigned STRK_W = 4;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOST     = 2'd3
  } state_e;

  // Reset: assert asynchronously, release after two clock edges.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge SYS_CLK_I or negedge SYS_RSTN_I) begin
    if (!SYS_RSTN_I) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Sample delay. A count of 0 means idle, and a new SEC_I reloads the count.
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_d;
  logic             fire_c;

  always_comb begin
    dly_d  = dly_q;
    fire_c = 1'b0;
    if (SEC_I) begin
      dly_d = DLY_W'(C_SAMPLE_DLY - 1);
      if (C_SAMPLE_DLY == 1) begin
        fire_c = 1'b1;
      end
    end else if (dly_q != '0) begin
      dly_d = dly_q - DLY_W'(1);
      if (dly_q == DLY_W'(1)) begin
        fire_c = 1'b1;
      end
    end
  end

  logic                eval_q;
  logic [C_CNT_BW-1:0] freq_q;

  always_ff @(posedge SYS_CLK_I or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      dly_q  <= '0;
      eval_q <= 1'b0;
      freq_q <= '0;
    end else begin
      dly_q  <= dly_d;
      eval_q <= fire_c;
      if (fire_c) begin
        freq_q <= FREQ_HZ_I;
      end
    end
  end

  // Classify the captured sample. The extra bit keeps the comparisons free of wrap-around.
  logic [EXT_W-1:0] freq_x;
  logic [EXT_W-1:0] exp_x;
  logic [EXT_W-1:0] tol_x;
  logic [EXT_W-1:0] dev_x;
  logic             absent_c;
  logic             in_range_c;

  always_comb begin
    freq_x     = EXT_W'(freq_q);
    exp_x      = EXT_W'(EXPECT_HZ_I);
    tol_x      = EXT_W'(TOL_HZ_I);
    dev_x      = (freq_x >= exp_x) ? (freq_x - exp_x) : (exp_x - freq_x);
    absent_c   = (freq_q == '0);
    // A tolerance at or above nominal accepts every present clock.
    in_range_c = !absent_c && ((tol_x >= exp_x) || (dev_x <= tol_x));
  end

  // Streak counters saturate at 15.
  logic [STRK_W-1:0] good_q;
  logic [STRK_W-1:0] bad_q;
  logic [STRK_W-1:0] good_inc;
  logic [STRK_W-1:0] bad_inc;

  always_comb begin
    good_inc = (good_q == '1) ? good_q : (good_q + STRK_W'(1));
    bad_inc  = (bad_q  == '1) ? bad_q  : (bad_q  + STRK_W'(1));
  end

  // Lock state machine with registered flags and the sticky alarm.
  state_e state_q;
  logic   ok_q;
  logic   lost_q;
  logic   alarm_q;

  always_ff @(posedge SYS_CLK_I or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= ST_INIT;
      good_q  <= '0;
      bad_q   <= '0;
      ok_q    <= 1'b0;
      lost_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      // A clear is applied first so that a set in the same cycle overrides it.
      if (STICKY_CLR_I) begin
        alarm_q <= 1'b0;
      end
      if (eval_q) begin
        if (absent_c) begin
          state_q <= ST_LOST;
          ok_q    <= 1'b0;
          lost_q  <= 1'b1;
          good_q  <= '0;
          bad_q   <= '0;
          if (state_q != ST_LOST) begin
            alarm_q <= 1'b1;
          end
        end else if (in_range_c) begin
          bad_q  <= '0;
          good_q <= good_inc;
          if ((state_q != ST_LOCKED) && (good_inc >= STRK_W'(C_GOOD_CNT))) begin
            state_q <= ST_LOCKED;
            ok_q    <= 1'b1;
            lost_q  <= 1'b0;
          end
        end else begin
          good_q <= '0;
          bad_q  <= bad_inc;
          case (state_q)
            ST_LOST: begin
              state_q <= ST_UNLOCKED;
              ok_q    <= 1'b0;
              lost_q  <= 1'b0;
            end
            ST_INIT, ST_LOCKED: begin
              if (bad_inc >= STRK_W'(C_BAD_CNT)) begin
                state_q <= ST_UNLOCKED;
                ok_q    <= 1'b0;
                lost_q  <= 1'b0;
                if (state_q == ST_LOCKED) begin
                  alarm_q <= 1'b1;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifdef FREQ_STATUS_MONITOR_MINMAX_EN
  // Min/max of the non-zero samples. A clear that coincides with a sample
  // starts the new window from that sample.
  logic [C_CNT_BW-1:0] min_q;
  logic [C_CNT_BW-1:0] max_q;

  always_ff @(posedge SYS_CLK_I or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      min_q <= '1;
      max_q <= '0;
    end else if (STICKY_CLR_I) begin
      if (eval_q && !absent_c) begin
        min_q <= freq_q;
        max_q <= freq_q;
      end else begin
        min_q <= '1;
        max_q <= '0;
      end
    end else if (eval_q && !absent_c) begin
      if (freq_q < min_q) begin
        min_q <= freq_q;
      end
      if (freq_q > max_q) begin
        max_q <= freq_q;
      end
    end
  end

  assign FREQ_MIN_O = min_q;
  assign FREQ_MAX_O = max_q;
`else
  assign FREQ_MIN_O = '0;
  assign FREQ_MAX_O = '0;
`endif

  assign EVAL_VALID_O   = eval_q;
  assign STATE_O        = state_q;
  assign FREQ_OK_O      = ok_q;
  assign CLK_LOST_O     = lost_q;
  assign ALARM_STICKY_O = alarm_q;
  assign FREQ_HZ_O      = freq_q;

endmodule

// File: tb/tb_freq_status_monitor.sv
// Self-checking bench for freq_status_monitor. Randomized samples are
// scored against a behavioural model of the lock rules.
module tb_freq_status_monitor;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;
  localparam int unsigned G = 3;
  localparam int unsigned B = 2;
  localparam longint      ALL_ONES = 64'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sec = 1'b0;
  logic [W-1:0] freq_in = '0;
  logic [W-1:0] expect_in = '0;
  logic [W-1:0] tol_in = '0;
  logic         clr = 1'b0;
  logic         eval_o;
  logic [1:0]   state_o;
  logic         ok_o;
  logic         lost_o;
  logic         alarm_o;
  logic [W-1:0] freq_o;
  logic [W-1:0] min_o;
  logic [W-1:0] max_o;

  always #5 clk = ~clk;

  freq_status_monitor #(
    .C_CNT_BW(W), .C_SAMPLE_DLY(D), .C_GOOD_CNT(G), .C_BAD_CNT(B)
  ) dut (
    .SYS_CLK_I(clk), .SYS_RSTN_I(rst_n), .SEC_I(sec), .FREQ_HZ_I(freq_in),
    .EXPECT_HZ_I(expect_in), .TOL_HZ_I(tol_in), .STICKY_CLR_I(clr),
    .EVAL_VALID_O(eval_o), .STATE_O(state_o), .FREQ_OK_O(ok_o),
    .CLK_LOST_O(lost_o), .ALARM_STICKY_O(alarm_o), .FREQ_HZ_O(freq_o),
    .FREQ_MIN_O(min_o), .FREQ_MAX_O(max_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  int     m_state;
  int     m_good;
  int     m_bad;
  bit     m_alarm;
  longint m_freq;
  longint m_min;
  longint m_max;
  longint m_exp;
  longint m_tol;

  function automatic void model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_alarm = 0;
    m_freq = 0; m_min = ALL_ONES; m_max = 0;
  endfunction

  function automatic bit model_in_range(input longint f);
    longint dev;
    if (f == 0) return 0;
    if (m_tol >= m_exp) return 1;
    dev = (f > m_exp) ? f - m_exp : m_exp - f;
    return dev <= m_tol;
  endfunction

  function automatic void model_eval(input longint f, input bit c);
    int prev;
    prev = m_state;
    if (f == 0) begin
      m_state = 3; m_good = 0; m_bad = 0;
    end else if (model_in_range(f)) begin
      m_bad = 0;
      m_good = (m_good >= 15) ? 15 : m_good + 1;
      if (m_state != 1 && m_good >= int'(G)) m_state = 1;
    end else begin
      m_good = 0;
      m_bad = (m_bad >= 15) ? 15 : m_bad + 1;
      if (m_state == 3) m_state = 2;
      else if (m_state != 2 && m_bad >= int'(B)) m_state = 2;
    end
    if ((prev == 1 && m_state != 1) || (prev != 3 && m_state == 3)) m_alarm = 1;
    else if (c) m_alarm = 0;
    if (c) begin
      m_min = ALL_ONES; m_max = 0;
    end
    if (f != 0) begin
      if (f < m_min) m_min = f;
      if (f > m_max) m_max = f;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "/state"}, 64'(state_o), 64'(m_state));
    check({tag, "/ok"}, 64'(ok_o), 64'(m_state == 1));
    check({tag, "/lost"}, 64'(lost_o), 64'(m_state == 3));
    check({tag, "/alarm"}, 64'(alarm_o), 64'(m_alarm));
    check({tag, "/freq"}, 64'(freq_o), m_freq);
`ifdef FREQ_STATUS_MONITOR_MINMAX_EN
    check({tag, "/min"}, 64'(min_o), m_min);
    check({tag, "/max"}, 64'(max_o), m_max);
`else
    check({tag, "/min"}, 64'(min_o), 64'd0);
    check({tag, "/max"}, 64'(max_o), 64'd0);
`endif
  endtask

  task automatic set_ref(input longint e, input longint t);
    m_exp = e; m_tol = t;
    expect_in = e[W-1:0]; tol_in = t[W-1:0];
  endtask

  // Pulse SEC_I and, if restart_at > 0, pulse it again at that cycle.
  // Then check the evaluation timing and the resulting status.
  task automatic run_sample(input longint f, input int restart_at, input bit c);
    int early;
    int exp_t;
    exp_t = (restart_at > 0) ? restart_at + int'(D) : int'(D);
    early = 0;
    freq_in = f[W-1:0];
    sec = 1'b1;
    for (int t = 1; t <= exp_t; t++) begin
      tick();
      sec = (t == restart_at);
      if (t < exp_t && eval_o) early++;
    end
    check("eval_early", 64'(early), 64'd0);
    check("eval_pulse", 64'(eval_o), 64'd1);
    check("freq_capture", 64'(freq_o), f);
    m_freq = f;
    clr = c;
    model_eval(f, c);
    tick();
    clr = 1'b0;
    check("eval_single", 64'(eval_o), 64'd0);
    check_outputs("post_eval");
    repeat (2) tick();
  endtask

  task automatic clear_only();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_alarm = 0; m_min = ALL_ONES; m_max = 0;
    check_outputs("clear");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_eval", 64'(eval_o), 64'd0);
    check_outputs("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // SEC_I at cycle 0, reset at cycle 6: the pending delay must not produce an evaluation.
  task automatic reset_cancel();
    int evals;
    freq_in = 32'd100000000;
    sec = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      sec = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("cancel_rst");
    tick();
    rst_n = 1'b1;
    evals = 0;
    repeat (20) begin
      tick();
      if (eval_o) evals++;
    end
    check("cancel_evals", 64'(evals), 64'd0);
    check_outputs("cancel_after");
  endtask

  initial begin
    longint f;
    int r;
    set_ref(100000000, 1000);
    #1;
    do_reset();

    // Three in-range samples lock.
    repeat (3) run_sample(100000500, 0, 0);
    // Tolerance edges.
    run_sample(100001000, 0, 0);
    run_sample(99999000, 0, 0);
    run_sample(100001001, 0, 0);
    run_sample(100000000, 0, 0);
    // Loss and recovery, with the alarm kept latched.
    run_sample(0, 0, 0);
    repeat (3) run_sample(100000000, 0, 0);
    // The bad streak is broken by a good sample.
    run_sample(100002000, 0, 0);
    run_sample(100000000, 0, 0);
    run_sample(100002000, 0, 0);
    run_sample(100002000, 0, 0);
    run_sample(100002000, 0, 0);
    // A set coincides with a clear: the set wins.
    repeat (3) run_sample(100000000, 0, 0);
    clear_only();
    run_sample(100002000, 0, 0);
    run_sample(100002000, 0, 1);
    // Min/max trackers.
    clear_only();
    run_sample(99999000, 0, 0);
    run_sample(100001000, 0, 0);
    run_sample(0, 0, 0);
    clear_only();
    // A second SEC_I restarts the delay.
    run_sample(100000000, 4, 0);
    reset_cancel();

    // Randomized samples around nominal.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) f = 0;
      else if (r <= 5) f = 100000000 + longint'($urandom_range(0, 2000)) - 1000;
      else if (r <= 8) f = ($urandom_range(0, 1) == 1) ? 100001000 + longint'($urandom_range(1, 50000))
                                                       : 99999000 - longint'($urandom_range(1, 50000));
      else f = longint'($urandom);
      run_sample(f, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1)) : 0,
                 $urandom_range(0, 7) == 0);
    end

    // With a tolerance at or above nominal, every present clock is in range.
    set_ref(100000000, 100000000);
    for (int i = 0; i < 10; i++) begin
      f = ($urandom_range(0, 4) == 0) ? 0 : longint'($urandom_range(1, 32'hFFFF_FFFF));
      run_sample(f, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
